// File: rtl/io_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and an INTR/INT_ACK handshake.
// Registers: CTRL (EN/AUTO/IE), LOAD, COUNT, STATUS (PEND/OVR, write-1-to-clear).
module io_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] D_in,
  input  logic        IO_cs,
  input  logic        IO_rd,
  input  logic        IO_wr,
  input  logic        INT_ACK,
  output logic [31:0] D_out,
  output logic        INTR
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

  logic [2:0]     ctrl_q, ctrl_d;
  logic [31:0]    load_q, load_d;
  logic [31:0]    count_q, count_d;
  logic [PsW-1:0] ps_q, ps_d;
  logic           pend_q, pend_d;
  logic           ovr_q, ovr_d;
  logic [31:0]    dout_q, dout_d;
  logic           intr_q, intr_d;

  logic        wr_en, rd_en;
  logic [1:0]  sel;
  logic        ctrl_wr, load_wr, count_wr, stat_wr;
  logic        tick, expire;
  logic [31:0] rdata;

  // Only Address[3:2] matters; chip-select does the rest of the decode.
  logic unused_addr;
  assign unused_addr = ^{Address[31:4], Address[1:0]};

  always_comb begin
    wr_en    = IO_cs & IO_wr;
    rd_en    = IO_cs & IO_rd;
    sel      = Address[3:2];
    ctrl_wr  = wr_en & (sel == 2'd0);
    load_wr  = wr_en & (sel == 2'd1);
    count_wr = wr_en & (sel == 2'd2);
    stat_wr  = wr_en & (sel == 2'd3);

    ctrl_d = ctrl_wr ? D_in[2:0] : ctrl_q;
    load_d = load_wr ? D_in : load_q;

    // A write that clears EN suppresses a tick landing on the same edge.
    tick = ctrl_q[0] & (ps_q == PsMax) & ctrl_d[0];
    ps_d = (ctrl_q[0] && ctrl_d[0] && (ps_q != PsMax)) ? ps_q + PsW'(1) : '0;

    expire  = 1'b0;
    count_d = count_q;
    if (count_wr) begin
      count_d = D_in;
    end else if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        expire  = 1'b1;
        count_d = ctrl_q[1] ? load_d : 32'd0;
      end
    end

    // Expiry beats any clear on the same edge.
    pend_d = (pend_q & ~(stat_wr & D_in[0]) & ~INT_ACK) | expire;
    ovr_d  = (ovr_q & ~(stat_wr & D_in[1])) | (expire & pend_q);

    rdata = '0;
    unique case (sel)
      2'd0: rdata = {29'd0, ctrl_q};
      2'd1: rdata = load_q;
      2'd2: rdata = count_q;
      2'd3: rdata = {30'd0, ovr_q, pend_q};
      default: rdata = '0;
    endcase
    dout_d = rd_en ? rdata : dout_q;

    // INTR comes straight from a flop so it cannot glitch.
    intr_d = pend_d & ctrl_d[2];
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      ps_q    <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
      intr_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      ps_q    <= ps_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
      intr_q  <= intr_d;
    end
  end

  assign D_out = dout_q;
  assign INTR  = intr_q;

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: two instances (PRESCALE 1 and 4) share one bus and are checked every
// cycle against a behavioural model, plus directed scenarios and a random phase.
module tb_io_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, din;
  logic        cs, rd, wr, ack;
  logic [31:0] dout0, dout1;
  logic        intr0, intr1;

  always #5 clk = ~clk;

  io_timer #(.PRESCALE(1)) u_p1 (
    .sys_clk(clk), .reset(rst_n), .Address(addr), .D_in(din), .IO_cs(cs), .IO_rd(rd),
    .IO_wr(wr), .INT_ACK(ack), .D_out(dout0), .INTR(intr0)
  );

  io_timer #(.PRESCALE(4)) u_p4 (
    .sys_clk(clk), .reset(rst_n), .Address(addr), .D_in(din), .IO_cs(cs), .IO_rd(rd),
    .IO_wr(wr), .INT_ACK(ack), .D_out(dout1), .INTR(intr1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model, one entry per instance.
  int unsigned mp[2] = '{1, 4};
  logic [2:0]  m_ctrl[2];
  logic [31:0] m_load[2], m_count[2], m_dout[2];
  int unsigned m_ps[2];
  logic        m_pend[2], m_ovr[2], m_intr[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ctrl[m] = '0; m_load[m] = '0; m_count[m] = '0; m_dout[m] = '0;
      m_ps[m] = 0; m_pend[m] = 1'b0; m_ovr[m] = 1'b0; m_intr[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m);
    bit          do_wr, do_rd, tick, expire, en_clr, old_pend;
    int          sel;
    logic [31:0] new_load;
    logic [31:0] cur[4];
    do_wr = cs && wr;
    do_rd = cs && rd;
    sel   = int'(addr[3:2]);
    cur[0] = {29'd0, m_ctrl[m]};
    cur[1] = m_load[m];
    cur[2] = m_count[m];
    cur[3] = {30'd0, m_ovr[m], m_pend[m]};
    if (do_rd) m_dout[m] = cur[sel];
    en_clr   = do_wr && sel == 0 && !din[0];
    tick     = m_ctrl[m][0] && (m_ps[m] == mp[m] - 1) && !en_clr;
    new_load = (do_wr && sel == 1) ? din : m_load[m];
    expire   = 0;
    if (do_wr && sel == 2) m_count[m] = din;
    else if (tick && m_count[m] == 1) begin
      expire = 1;
      m_count[m] = m_ctrl[m][1] ? new_load : 32'd0;
    end else if (tick && m_count[m] > 1) m_count[m] = m_count[m] - 1;
    if (!m_ctrl[m][0] || en_clr || m_ps[m] == mp[m] - 1) m_ps[m] = 0;
    else m_ps[m] = m_ps[m] + 1;
    old_pend = m_pend[m];
    if (ack) m_pend[m] = 1'b0;
    if (do_wr && sel == 3 && din[0]) m_pend[m] = 1'b0;
    if (do_wr && sel == 3 && din[1]) m_ovr[m] = 1'b0;
    if (expire) begin
      if (old_pend) m_ovr[m] = 1'b1;
      m_pend[m] = 1'b1;
    end
    m_load[m] = new_load;
    if (do_wr && sel == 0) m_ctrl[m] = din[2:0];
    m_intr[m] = m_pend[m] & m_ctrl[m][2];
  endtask

  task automatic compare_all();
    check_eq("dout_p1", dout0, m_dout[0]);
    check_eq("intr_p1", {31'd0, intr0}, {31'd0, m_intr[0]});
    check_eq("dout_p4", dout1, m_dout[1]);
    check_eq("intr_p4", {31'd0, intr1}, {31'd0, m_intr[1]});
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = idx[1:0];
    return a;
  endfunction

  task automatic op(input bit c, input bit r, input bit w, input logic [31:0] a,
                    input logic [31:0] d, input bit k);
    cs = c; rd = r; wr = w; addr = a; din = d; ack = k;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
    cs = 0; rd = 0; wr = 0; ack = 0; addr = $urandom; din = $urandom;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] d);
    op(1, 0, 1, mk_addr(idx), d, 0);
  endtask

  task automatic rd_reg(input int idx);
    op(1, 1, 0, mk_addr(idx), $urandom, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 0, $urandom, $urandom, 0);
  endtask

  task automatic ack_pulse();
    op(0, 0, 0, $urandom, $urandom, 1);
  endtask

  initial begin
    int r, idx;
    logic [31:0] d;
    rst_n = 1'b0; cs = 0; rd = 0; wr = 0; ack = 0; addr = '0; din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and register readback.
    check_eq("rst_intr", {31'd0, intr0}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i);
      check_eq("rst_read", dout0, 32'd0);
    end
    wr_reg(1, 32'hDEADBEEF);
    wr_reg(0, 32'hFFFFFFFF);
    rd_reg(1);
    check_eq("load_rb", dout0, 32'hDEADBEEF);
    rd_reg(0);
    check_eq("ctrl_rb", dout1, 32'h0000_0007);
    wr_reg(0, 0);
    wr_reg(1, 0);

    // One-shot on the PRESCALE=1 instance.
    wr_reg(2, 3);
    wr_reg(0, 5);
    idle(2);
    check_eq("oneshot_early", {31'd0, intr0}, 32'd0);
    idle(1);
    check_eq("oneshot_intr", {31'd0, intr0}, 32'd1);
    rd_reg(3);
    check_eq("oneshot_pend", dout0, 32'd1);
    rd_reg(2);
    check_eq("oneshot_cnt", dout0, 32'd0);
    idle(20);
    rd_reg(2);
    check_eq("oneshot_hold", dout0, 32'd0);
    ack_pulse();
    check_eq("ack_intr", {31'd0, intr0}, 32'd0);
    rd_reg(3);
    check_eq("ack_status", dout0, 32'd0);
    wr_reg(0, 0);
    wr_reg(3, 3);

    // Auto-reload on the PRESCALE=4 instance: expiry every 8 cycles.
    wr_reg(1, 2);
    wr_reg(2, 2);
    wr_reg(0, 7);
    idle(7);
    check_eq("auto_early", {31'd0, intr1}, 32'd0);
    idle(1);
    check_eq("auto_first", {31'd0, intr1}, 32'd1);
    idle(8);
    rd_reg(3);
    check_eq("auto_ovr", dout1, 32'd3);
    wr_reg(3, 3);
    rd_reg(3);
    check_eq("auto_w1c", dout1, 32'd0);
    idle(5);
    check_eq("auto_third", {31'd0, intr1}, 32'd1);
    ack_pulse();
    check_eq("auto_ack", {31'd0, intr1}, 32'd0);
    idle(6);
    ack_pulse();
    check_eq("ack_vs_expiry", {31'd0, intr1}, 32'd1);
    wr_reg(3, 3);
    idle(6);
    wr_reg(2, 10);
    rd_reg(3);
    check_eq("cntwr_vs_exp_pend", dout1, 32'd0);
    rd_reg(2);
    check_eq("cntwr_vs_exp_cnt", dout1, 32'd10);
    wr_reg(0, 0);
    wr_reg(2, 1);
    wr_reg(0, 7);
    idle(3);
    wr_reg(3, 1);
    check_eq("w1c_vs_exp_intr", {31'd0, intr1}, 32'd1);
    rd_reg(3);
    check_eq("w1c_vs_exp_stat", dout1, 32'd1);

    // Asynchronous reset with COUNT=5 and INTR=1.
    wr_reg(0, 0);
    wr_reg(3, 3);
    wr_reg(2, 1);
    wr_reg(0, 5);
    idle(1);
    wr_reg(0, 4);
    wr_reg(2, 5);
    rd_reg(2);
    check_eq("pre_rst_cnt", dout0, 32'd5);
    check_eq("pre_rst_intr", {31'd0, intr0}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_dout", dout0 | dout1, 32'd0);
    check_eq("async_rst_intr", {30'd0, intr1, intr0}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check_eq("post_rst_intr", {30'd0, intr1, intr0}, 32'd0);
    rd_reg(2);
    check_eq("post_rst_cnt", dout0, 32'd0);

    // Random phase.
    for (int n = 0; n < 1500; n++) begin
      r   = $urandom_range(0, 99);
      idx = $urandom_range(0, 3);
      case (idx)
        1, 2:    d = $urandom_range(0, 6);
        default: d = $urandom;
      endcase
      if (r < 40)      op(0, 0, 0, $urandom, $urandom, $urandom_range(0, 7) == 0);
      else if (r < 65) op(1, 0, 1, mk_addr(idx), d, $urandom_range(0, 9) == 0);
      else if (r < 90) op(1, 1, 0, mk_addr(idx), d, $urandom_range(0, 9) == 0);
      else if (r < 95) op(1, 1, 1, mk_addr(idx), d, $urandom_range(0, 9) == 0);
      else             op(0, 1, 1, mk_addr(idx), d, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
